// File: rtl/legv8_ctrl_pkg.sv
// Shared opcode, ALU and exception encodings for the LEGv8 control decoder.
package legv8_ctrl_pkg;

  localparam int OPW = 11;

  localparam logic [OPW-1:0] OP_LDUR     = 11'h7C2;
  localparam logic [OPW-1:0] OP_STUR     = 11'h7C0;
  localparam logic [OPW-1:0] OP_CBZ_BASE = 11'h5A0;
  localparam logic [OPW-1:0] OP_ADD      = 11'h458;
  localparam logic [OPW-1:0] OP_SUB      = 11'h658;
  localparam logic [OPW-1:0] OP_AND      = 11'h450;
  localparam logic [OPW-1:0] OP_ORR      = 11'h550;
  localparam logic [OPW-1:0] OP_ERET     = 11'h6B4;
  localparam logic [OPW-1:0] OP_MRS      = 11'h6A9;

  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_PASS  = 2'b01,
    ALUOP_RTYPE = 2'b10,
    ALUOP_PASS2 = 2'b11
  } alu_op_t;

  localparam logic [3:0] ALU_ADD   = 4'b0010;
  localparam logic [3:0] ALU_SUB   = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0000;
  localparam logic [3:0] ALU_ORR   = 4'b0001;
  localparam logic [3:0] ALU_PASSB = 4'b0111;

  localparam logic [3:0] EST_NONE   = 4'b0000;
  localparam logic [3:0] EST_EXTIRQ = 4'b0001;
  localparam logic [3:0] EST_BADOP  = 4'b0010;

  typedef struct packed {
    logic       reg2loc;
    logic [1:0] alu_src;
    logic       mem_to_reg;
    logic       reg_write;
    logic       mem_read;
    logic       mem_write;
    logic       branch;
    logic       eret;
  } ctrl_t;

  // CBZ ignores the low three opcode bits (register-field overlap).
  function automatic logic is_cbz(input logic [OPW-1:0] op);
    return op[OPW-1:3] == OP_CBZ_BASE[OPW-1:3];
  endfunction

endpackage

// File: rtl/legv8_alu_fdec.sv
// ALU function decoder: AluOp plus opcode field to the 4-bit ALU control code.
module legv8_alu_fdec
  import legv8_ctrl_pkg::*;
(
  input  alu_op_t          alu_op,
  input  logic [OPW-1:0]   instr,
  output logic [3:0]       alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (alu_op)
      ALUOP_ADD:   alu_control = ALU_ADD;
      ALUOP_PASS:  alu_control = ALU_PASSB;
      ALUOP_PASS2: alu_control = ALU_PASSB;
      ALUOP_RTYPE: begin
        case (instr)
          OP_ADD:  alu_control = ALU_ADD;
          OP_SUB:  alu_control = ALU_SUB;
          OP_AND:  alu_control = ALU_AND;
          OP_ORR:  alu_control = ALU_ORR;
          default: alu_control = ALU_ADD;
        endcase
      end
      default:     alu_control = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/legv8_ctrl_decoder.sv
// Registered LEGv8 main + ALU control decoder with exception status.
// Define EXT_IRQ_EN to enable the external-IRQ status override and acknowledge.
module legv8_ctrl_decoder
  import legv8_ctrl_pkg::*;
#(
  parameter int OPW = 11
) (
  input  logic           clk,
  input  logic           reset,
  input  logic [OPW-1:0] instr,
  input  logic           ExcAck,
  input  logic           ExtIRQ,
  output logic [3:0]     AluControl,
  output logic [1:0]     AluSrc,
  output logic           reg2loc,
  output logic           regWrite,
  output logic           memtoReg,
  output logic           memRead,
  output logic           memWrite,
  output logic           Branch,
  output logic [3:0]     EStatus,
  output logic           ERet,
  output logic           Exc,
  output logic           ExtIAck
);

  ctrl_t      ctrl_d, ctrl_q;
  alu_op_t    alu_op;
  logic       op_valid;
  logic [3:0] alu_control_d;
  logic [3:0] alu_control_q;
  logic [3:0] est_d, est_q;
  logic       exc_d, exc_q;
  logic       irq_d, ack_d, ack_q;

  always_comb begin
    ctrl_d   = '0;
    alu_op   = ALUOP_ADD;
    op_valid = 1'b1;
    case (instr)
      OP_LDUR: begin
        ctrl_d.alu_src    = 2'b01;
        ctrl_d.mem_to_reg = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_read   = 1'b1;
      end
      OP_STUR: begin
        ctrl_d.reg2loc   = 1'b1;
        ctrl_d.alu_src   = 2'b01;
        ctrl_d.mem_write = 1'b1;
      end
      OP_ADD, OP_SUB, OP_AND, OP_ORR: begin
        ctrl_d.reg_write = 1'b1;
        alu_op           = ALUOP_RTYPE;
      end
      OP_ERET: begin
        ctrl_d.branch = 1'b1;
        ctrl_d.eret   = 1'b1;
        alu_op        = ALUOP_PASS;
      end
      OP_MRS: begin
        ctrl_d.reg2loc   = 1'b1;
        ctrl_d.alu_src   = 2'b10;
        ctrl_d.reg_write = 1'b1;
        alu_op           = ALUOP_PASS;
      end
      default: begin
        if (is_cbz(instr)) begin
          ctrl_d.reg2loc = 1'b1;
          ctrl_d.branch  = 1'b1;
          alu_op         = ALUOP_PASS;
        end else begin
          op_valid = 1'b0;
        end
      end
    endcase
  end

  legv8_alu_fdec u_alu_fdec (
    .alu_op      (alu_op),
    .instr       (instr),
    .alu_control (alu_control_d)
  );

`ifdef EXT_IRQ_EN
  assign irq_d = ExtIRQ;
  assign ack_d = ExcAck & ExtIRQ;
`else
  logic unused_irq_inputs;
  assign unused_irq_inputs = ExtIRQ ^ ExcAck;
  assign irq_d = 1'b0;
  assign ack_d = 1'b0;
`endif

  // A pending IRQ outranks an invalid-opcode cause.
  assign est_d = irq_d ? EST_EXTIRQ : (op_valid ? EST_NONE : EST_BADOP);
  assign exc_d = irq_d | ~op_valid;

  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl_q        <= '0;
      alu_control_q <= 4'b0000;
      est_q         <= EST_NONE;
      exc_q         <= 1'b0;
      ack_q         <= 1'b0;
    end else begin
      ctrl_q        <= ctrl_d;
      alu_control_q <= alu_control_d;
      est_q         <= est_d;
      exc_q         <= exc_d;
      ack_q         <= ack_d;
    end
  end

  assign reg2loc    = ctrl_q.reg2loc;
  assign AluSrc     = ctrl_q.alu_src;
  assign memtoReg   = ctrl_q.mem_to_reg;
  assign regWrite   = ctrl_q.reg_write;
  assign memRead    = ctrl_q.mem_read;
  assign memWrite   = ctrl_q.mem_write;
  assign Branch     = ctrl_q.branch;
  assign ERet       = ctrl_q.eret;
  assign AluControl = alu_control_q;
  assign EStatus    = est_q;
  assign Exc        = exc_q;
  assign ExtIAck    = ack_q;

endmodule

// File: tb/tb_legv8_ctrl_decoder.sv
// Directed bench for legv8_ctrl_decoder; IRQ expectations follow EXT_IRQ_EN.
module tb_legv8_ctrl_decoder;

`ifdef EXT_IRQ_EN
  localparam bit IRQ_EN = 1'b1;
`else
  localparam bit IRQ_EN = 1'b0;
`endif

  // Control bundle order: reg2loc, AluSrc[1:0], memtoReg, regWrite, memRead, memWrite, Branch, ERet
  localparam logic [8:0] C_NONE = 9'b0_00_0_0_0_0_0_0;
  localparam logic [8:0] C_LDUR = 9'b0_01_1_1_1_0_0_0;
  localparam logic [8:0] C_STUR = 9'b1_01_0_0_0_1_0_0;
  localparam logic [8:0] C_CBZ  = 9'b1_00_0_0_0_0_1_0;
  localparam logic [8:0] C_RTYP = 9'b0_00_0_1_0_0_0_0;
  localparam logic [8:0] C_ERET = 9'b0_00_0_0_0_0_1_1;
  localparam logic [8:0] C_MRS  = 9'b1_10_0_1_0_0_0_0;

  logic        clk = 1'b0;
  logic        reset;
  logic [10:0] instr;
  logic        ExcAck, ExtIRQ;
  logic [3:0]  AluControl, EStatus;
  logic [1:0]  AluSrc;
  logic        reg2loc, regWrite, memtoReg, memRead, memWrite, Branch;
  logic        ERet, Exc, ExtIAck;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  legv8_ctrl_decoder dut (
    .clk        (clk),
    .reset      (reset),
    .instr      (instr),
    .ExcAck     (ExcAck),
    .ExtIRQ     (ExtIRQ),
    .AluControl (AluControl),
    .AluSrc     (AluSrc),
    .reg2loc    (reg2loc),
    .regWrite   (regWrite),
    .memtoReg   (memtoReg),
    .memRead    (memRead),
    .memWrite   (memWrite),
    .Branch     (Branch),
    .EStatus    (EStatus),
    .ERet       (ERet),
    .Exc        (Exc),
    .ExtIAck    (ExtIAck)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Apply inputs mid-cycle, then sample just after the following rising edge.
  task automatic drive(input logic [10:0] op, input logic irq, input logic ack, input logic rst);
    @(negedge clk);
    instr  = op;
    ExtIRQ = irq;
    ExcAck = ack;
    reset  = rst;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string tag, input logic [8:0] ctrl, input logic [3:0] alu,
                            input logic [3:0] est, input logic exc, input logic iack);
    chk({tag, ".ctrl"}, {23'd0, reg2loc, AluSrc, memtoReg, regWrite, memRead, memWrite, Branch, ERet},
        {23'd0, ctrl});
    chk({tag, ".alu"},  {28'd0, AluControl}, {28'd0, alu});
    chk({tag, ".est"},  {28'd0, EStatus}, {28'd0, est});
    chk({tag, ".exc"},  {31'd0, Exc}, {31'd0, exc});
    chk({tag, ".iack"}, {31'd0, ExtIAck}, {31'd0, iack});
  endtask

  initial begin
    reset = 1'b1; instr = 11'h000; ExtIRQ = 1'b0; ExcAck = 1'b0;

    // Reset wins over a valid opcode and a pending IRQ.
    drive(11'h458, 1'b1, 1'b1, 1'b1);
    expect_out("reset", C_NONE, 4'b0000, 4'b0000, 1'b0, 1'b0);
    drive(11'h458, 1'b0, 1'b0, 1'b0);
    expect_out("add_after_reset", C_RTYP, 4'b0010, 4'b0000, 1'b0, 1'b0);

    drive(11'h7C2, 1'b0, 1'b0, 1'b0);
    expect_out("ldur", C_LDUR, 4'b0010, 4'b0000, 1'b0, 1'b0);
    drive(11'h7C0, 1'b0, 1'b0, 1'b0);
    expect_out("stur", C_STUR, 4'b0010, 4'b0000, 1'b0, 1'b0);
    drive(11'h5A3, 1'b0, 1'b0, 1'b0);
    expect_out("cbz3", C_CBZ, 4'b0111, 4'b0000, 1'b0, 1'b0);
    drive(11'h5A0, 1'b0, 1'b0, 1'b0);
    expect_out("cbz0", C_CBZ, 4'b0111, 4'b0000, 1'b0, 1'b0);
    drive(11'h5A7, 1'b0, 1'b0, 1'b0);
    expect_out("cbz7", C_CBZ, 4'b0111, 4'b0000, 1'b0, 1'b0);
    drive(11'h5A8, 1'b0, 1'b0, 1'b0);
    expect_out("cbz_edge_bad", C_NONE, 4'b0010, 4'b0010, 1'b1, 1'b0);

    drive(11'h458, 1'b0, 1'b0, 1'b0);
    expect_out("add", C_RTYP, 4'b0010, 4'b0000, 1'b0, 1'b0);
    // Outputs must not follow a new opcode before the next edge.
    @(negedge clk);
    instr = 11'h658;
    #1;
    chk("latency_hold.alu", {28'd0, AluControl}, 32'h2);
    @(posedge clk);
    #1;
    expect_out("sub", C_RTYP, 4'b0110, 4'b0000, 1'b0, 1'b0);
    drive(11'h450, 1'b0, 1'b0, 1'b0);
    expect_out("and", C_RTYP, 4'b0000, 4'b0000, 1'b0, 1'b0);
    drive(11'h550, 1'b0, 1'b0, 1'b0);
    expect_out("orr", C_RTYP, 4'b0001, 4'b0000, 1'b0, 1'b0);

    drive(11'h6B4, 1'b0, 1'b0, 1'b0);
    expect_out("eret", C_ERET, 4'b0111, 4'b0000, 1'b0, 1'b0);
    drive(11'h6A9, 1'b0, 1'b0, 1'b0);
    expect_out("mrs", C_MRS, 4'b0111, 4'b0000, 1'b0, 1'b0);
    drive(11'h7FF, 1'b0, 1'b0, 1'b0);
    expect_out("bad7ff", C_NONE, 4'b0010, 4'b0010, 1'b1, 1'b0);
    drive(11'h459, 1'b0, 1'b0, 1'b0);
    expect_out("bad459", C_NONE, 4'b0010, 4'b0010, 1'b1, 1'b0);

    drive(11'h7C2, 1'b1, 1'b1, 1'b0);
    expect_out("ldur_irq_ack", C_LDUR, 4'b0010, IRQ_EN ? 4'b0001 : 4'b0000, IRQ_EN, IRQ_EN);
    drive(11'h7C2, 1'b1, 1'b0, 1'b0);
    expect_out("ldur_irq_noack", C_LDUR, 4'b0010, IRQ_EN ? 4'b0001 : 4'b0000, IRQ_EN, 1'b0);
    drive(11'h7FF, 1'b1, 1'b0, 1'b0);
    expect_out("bad_irq", C_NONE, 4'b0010, IRQ_EN ? 4'b0001 : 4'b0010, 1'b1, 1'b0);
    drive(11'h458, 1'b0, 1'b1, 1'b0);
    expect_out("ack_without_irq", C_RTYP, 4'b0010, 4'b0000, 1'b0, 1'b0);

    // Mid-stream reset, then recovery one cycle after release.
    drive(11'h550, 1'b1, 1'b1, 1'b1);
    expect_out("reset_mid", C_NONE, 4'b0000, 4'b0000, 1'b0, 1'b0);
    drive(11'h550, 1'b0, 1'b0, 1'b0);
    expect_out("orr_after_reset", C_RTYP, 4'b0001, 4'b0000, 1'b0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
